network_ctrl_v: RTL

- Operand-network controller for one vector lane cluster.
- Shares the lane operand network between two requesters: normal instruction issue, and a multi-stage cross-lane reduction sequencer.
- Drives the network's request, 13-bit path-select and ALU-source-select inputs from registered outputs.
- During a reduction, it steps through log2(NUM_LANES) rotate-and-combine stages and waits for each stage's writeback before issuing the next.

---
 rtl/network_ctrl_v.sv | 332 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/network_ctrl_v.sv
// network_ctrl_v: operand-network controller for one vector lane cluster.
// Arbitrates the lane operand network between normal instruction issue and a
// multi-stage cross-lane reduction sequencer. The reduction steps through
// WIDTH_LANES rotate-and-combine stages and waits for each stage's writeback
// before issuing the next one.
// Network-facing outputs are registered. The two acks are decided in the same
// cycle as the request.
// Optional feature: define RED_TIMEOUT_EN to enable the writeback watchdog,
// which aborts a reduction stuck in WAIT after TIMEOUT_CYCLES.
module network_ctrl_v #(
    parameter int NUM_LANES      = 16,
    parameter int WIDTH_LANES    = $clog2(NUM_LANES),
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        I_Stall,
    input  logic        I_Issue_Req,
    input  logic [12:0] I_Issue_Sel_Path,
    input  logic [2:0]  I_Issue_Sel_Src,
    output logic        O_Issue_Ack,
    input  logic        I_Red_Req,
    input  logic [1:0]  I_Red_Src,
    output logic        O_Red_Ack,
    input  logic        I_Red_WB,
    output logic        O_Red_Busy,
    output logic        O_Red_Done,
    output logic        O_Red_Err,
    output logic [4:0]  O_Stage,
    output logic        O_Req,
    output logic [12:0] O_Sel_Path,
    output logic [2:0]  O_Sel_ALU_Src
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int              SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [4:0]      LAST_STAGE = 5'(WIDTH_LANES - 1);
    localparam logic [2:0]      RED_ALU    = 3'b011;

    // Reduction path: both read ports select the captured source, the
    // rotate field asks for a shift of 2^stage lanes.
    function automatic logic [12:0] red_path(input logic [1:0] src,
                                             input logic [3:0] stg);
        red_path = {1'b1, stg, 2'b00, 2'b00, src, src};
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic [4:0]      stage_r;
    logic [4:0]      stage_next_s;
    logic [1:0]      red_src_r;
    logic [1:0]      red_src_next_s;
    logic [SC_W-1:0] starve_r;
    logic [SC_W-1:0] starve_next_s;
    logic            issue_ack_s;
    logic            red_ack_s;
    logic            timeout_s;
    logic            last_stage_s;

    logic            req_r;
    logic [12:0]     path_r;
    logic [2:0]      alu_r;
    logic            busy_r;
    logic            done_r;
    logic            req_next_s;
    logic [12:0]     path_next_s;
    logic [2:0]      alu_next_s;

    assign last_stage_s = (stage_r == LAST_STAGE);

`ifdef RED_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wdog_r;
    logic [WD_W-1:0] wdog_next_s;
    logic            err_r;

    // Watchdog: zero outside WAIT, counts non-stalled WAIT cycles; a WB in the limit cycle wins.
    always_comb begin
        wdog_next_s = wdog_r;
        timeout_s   = 1'b0;
        if (state_r != ST_WAIT) begin
            wdog_next_s = {WD_W{1'b0}};
        end else if (!I_Stall) begin
            wdog_next_s = wdog_r + WD_W'(1);
            timeout_s   = (wdog_r == WD_LAST) && !I_Red_WB;
        end else begin
            wdog_next_s = wdog_r;
        end
    end

    // Watchdog counter and one-cycle error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_r <= {WD_W{1'b0}};
            err_r  <= 1'b0;
        end else begin
            wdog_r <= wdog_next_s;
            err_r  <= timeout_s;
        end
    end

    assign O_Red_Err = err_r;
`else
    assign timeout_s = 1'b0;
    assign O_Red_Err = 1'b0;
`endif

    // Arbitration in IDLE: issue wins unless the pending reduction has starved STARVE_MAX times.
    always_comb begin
        issue_ack_s = 1'b0;
        red_ack_s   = 1'b0;
        if (!reset && (state_r == ST_IDLE) && !I_Stall) begin
            if (I_Issue_Req && I_Red_Req) begin
                if (starve_r == STARVE_LIM) begin
                    red_ack_s = 1'b1;
                end else begin
                    issue_ack_s = 1'b1;
                end
            end else if (I_Issue_Req) begin
                issue_ack_s = 1'b1;
            end else if (I_Red_Req) begin
                red_ack_s = 1'b1;
            end else begin
                issue_ack_s = 1'b0;
                red_ack_s   = 1'b0;
            end
        end else begin
            issue_ack_s = 1'b0;
            red_ack_s   = 1'b0;
        end
    end

    assign O_Issue_Ack = issue_ack_s;
    assign O_Red_Ack   = red_ack_s;

    // Starvation counter: counts reduction losses, clears when the reduction wins or drops its request.
    always_comb begin
        starve_next_s = starve_r;
        if (!I_Red_Req) begin
            starve_next_s = {SC_W{1'b0}};
        end else if (red_ack_s) begin
            starve_next_s = {SC_W{1'b0}};
        end else if (issue_ack_s) begin
            starve_next_s = starve_r + SC_W'(1);
        end else begin
            starve_next_s = starve_r;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic for the reduction sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (red_ack_s) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (I_Stall) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (I_Red_WB) begin
                    if (last_stage_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_ISSUE;
                    end
                end else if (timeout_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Stage counter and captured reduction source.
    always_comb begin
        stage_next_s   = stage_r;
        red_src_next_s = red_src_r;
        case (state_r)
            ST_IDLE: begin
                if (red_ack_s) begin
                    stage_next_s   = 5'd0;
                    red_src_next_s = I_Red_Src;
                end else begin
                    stage_next_s   = stage_r;
                    red_src_next_s = red_src_r;
                end
            end
            ST_WAIT: begin
                if (I_Red_WB && !last_stage_s) begin
                    stage_next_s = stage_r + 5'd1;
                end else if (timeout_s) begin
                    stage_next_s = 5'd0;
                end else begin
                    stage_next_s = stage_r;
                end
            end
            ST_DONE: begin
                stage_next_s = 5'd0;
            end
            default: begin
                stage_next_s   = stage_r;
                red_src_next_s = red_src_r;
            end
        endcase
    end

    // Output logic: values the network will see next cycle, held on stall where required.
    always_comb begin
        req_next_s  = req_r;
        path_next_s = path_r;
        alu_next_s  = alu_r;
        case (state_r)
            ST_IDLE: begin
                if (I_Stall) begin
                    req_next_s  = req_r;
                    path_next_s = path_r;
                    alu_next_s  = alu_r;
                end else if (issue_ack_s) begin
                    req_next_s  = 1'b1;
                    path_next_s = I_Issue_Sel_Path;
                    alu_next_s  = I_Issue_Sel_Src;
                end else if (red_ack_s) begin
                    req_next_s  = 1'b1;
                    path_next_s = red_path(I_Red_Src, 4'd0);
                    alu_next_s  = RED_ALU;
                end else begin
                    req_next_s  = 1'b0;
                    path_next_s = 13'd0;
                    alu_next_s  = 3'd0;
                end
            end
            ST_ISSUE: begin
                if (I_Stall) begin
                    req_next_s  = req_r;
                    path_next_s = path_r;
                    alu_next_s  = alu_r;
                end else begin
                    req_next_s  = 1'b0;
                    path_next_s = 13'd0;
                    alu_next_s  = 3'd0;
                end
            end
            ST_WAIT: begin
                if (I_Red_WB && !last_stage_s) begin
                    req_next_s  = 1'b1;
                    path_next_s = red_path(red_src_r, stage_next_s[3:0]);
                    alu_next_s  = RED_ALU;
                end else begin
                    req_next_s  = 1'b0;
                    path_next_s = 13'd0;
                    alu_next_s  = 3'd0;
                end
            end
            ST_DONE: begin
                req_next_s  = 1'b0;
                path_next_s = 13'd0;
                alu_next_s  = 3'd0;
            end
            default: begin
                req_next_s  = 1'b0;
                path_next_s = 13'd0;
                alu_next_s  = 3'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_r   <= 5'd0;
            red_src_r <= 2'd0;
            starve_r  <= {SC_W{1'b0}};
            req_r     <= 1'b0;
            path_r    <= 13'd0;
            alu_r     <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            stage_r   <= stage_next_s;
            red_src_r <= red_src_next_s;
            starve_r  <= starve_next_s;
            req_r     <= req_next_s;
            path_r    <= path_next_s;
            alu_r     <= alu_next_s;
            busy_r    <= (next_state_s == ST_ISSUE) || (next_state_s == ST_WAIT);
            done_r    <= (next_state_s == ST_DONE);
        end
    end

    assign O_Req         = req_r;
    assign O_Sel_Path    = path_r;
    assign O_Sel_ALU_Src = alu_r;
    assign O_Red_Busy    = busy_r;
    assign O_Red_Done    = done_r;
    assign O_Stage       = stage_r;

endmodule
